// File: rtl/conv_pkg.sv
// conv_pkg: shared widths, FSM states and address/saturation helpers for conv3x3_engine
package conv_pkg;
    localparam int PIX_W = 8;
    localparam int ADDR_W = 10;
    localparam int ACC_W = 20;
    typedef enum logic [2:0] {IDLE, READ, FLUSH, STORE, DONE} state_t;
    function automatic logic [ADDR_W-1:0] tap_addr(input int r, input int c, input int k, input int w);
        return ADDR_W'((r + k / 3) * w + c + k % 3);
    endfunction
    function automatic logic signed [PIX_W-1:0] sat8(input logic signed [ACC_W-1:0] acc);
        return acc > 20'sd127 ? 8'sd127 : acc < -20'sd128 ? -8'sd128 : acc[PIX_W-1:0];
    endfunction
endpackage

// File: rtl/conv_if.sv
// conv_if: memory-read, kernel and result-store signals of the 3x3 convolution engine
interface conv_if;
    import conv_pkg::*;
    logic conv;
    logic signed [PIX_W-1:0] kernel [9];
    logic signed [PIX_W-1:0] data1, data2;
    logic [ADDR_W-1:0] addr1, addr2, address;
    logic load, store, done;
    logic signed [PIX_W-1:0] result;
    modport master (input conv, kernel, data1, data2, output addr1, addr2, load, result, address, store, done);
    modport slave (output conv, kernel, data1, data2, input addr1, addr2, load, result, address, store, done);
endinterface

// File: rtl/conv_mac2.sv
// conv_mac2: two signed 8x8 multipliers feeding a 20-bit accumulator with clear/enable
module conv_mac2 import conv_pkg::*; (
    input logic clk,
    input logic rst,
    input logic clr,
    input logic en,
    input logic signed [PIX_W-1:0] a1,
    input logic signed [PIX_W-1:0] b1,
    input logic signed [PIX_W-1:0] a2,
    input logic signed [PIX_W-1:0] b2,
    output logic signed [ACC_W-1:0] sum
);
    logic signed [ACC_W-1:0] acc;
    logic signed [2*PIX_W-1:0] m1, m2;
    always_comb begin
        m1 = a1 * b1;
        m2 = a2 * b2;
        sum = acc + ACC_W'(m1) + ACC_W'(m2);
    end
    always_ff @(posedge clk) begin
        if (rst || clr) acc <= '0;
        else if (en) acc <= sum;
    end
endmodule

// File: rtl/conv3x3_engine.sv
// conv3x3_engine: streaming 3x3 valid convolution, 7 cycles per output pixel.
// Define RELU_EN to clamp stored results at zero.
module conv3x3_engine import conv_pkg::*; #(
    parameter int H = 28,
    parameter int W = 28
) (
    input logic clk,
    input logic rst,
    conv_if.master bus
);
    state_t state;
    logic [ADDR_W-1:0] r, c, nr, nc;
    logic [2:0] p, mp;
    logic signed [PIX_W-1:0] ka, kb, res_next;
    logic signed [ACC_W-1:0] sum;
    logic last_col, last;
    // data arriving now belongs to the pair issued one cycle earlier; FLUSH sees pair 4
    always_comb begin
        mp = state == FLUSH ? 3'd4 : p - 3'd1;
        ka = bus.kernel[{mp, 1'b0}];
        kb = mp == 3'd4 ? '0 : bus.kernel[{mp, 1'b1}];
        res_next = sat8(sum);
`ifdef RELU_EN
        res_next = res_next[PIX_W-1] ? '0 : res_next;
`endif
        last_col = c == ADDR_W'(W - 3);
        last = last_col && r == ADDR_W'(H - 3);
        nc = last_col ? '0 : c + 1'b1;
        nr = last_col ? r + 1'b1 : r;
    end
    conv_mac2 mac (
        .clk(clk),
        .rst(rst),
        .clr(state == READ && p == 3'd0),
        .en((state == READ && p != 3'd0) || state == FLUSH),
        .a1(bus.data1),
        .b1(ka),
        .a2(bus.data2),
        .b2(kb),
        .sum(sum)
    );
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
            r <= '0;
            c <= '0;
            p <= '0;
            bus.addr1 <= '0;
            bus.addr2 <= '0;
            bus.load <= 1'b0;
            bus.result <= '0;
            bus.address <= '0;
            bus.store <= 1'b0;
            bus.done <= 1'b0;
        end else begin
            case (state)
                IDLE: if (bus.conv) begin
                    state <= READ;
                    r <= '0;
                    c <= '0;
                    p <= '0;
                    bus.addr1 <= tap_addr(0, 0, 0, W);
                    bus.addr2 <= tap_addr(0, 0, 1, W);
                    bus.load <= 1'b1;
                end
                READ: if (p == 3'd4) begin
                    state <= FLUSH;
                    bus.load <= 1'b0;
                end else begin
                    p <= p + 3'd1;
                    bus.addr1 <= tap_addr(int'(r), int'(c), 2 * int'(p) + 2, W);
                    bus.addr2 <= tap_addr(int'(r), int'(c), p == 3'd3 ? 8 : 2 * int'(p) + 3, W);
                end
                FLUSH: begin
                    state <= STORE;
                    bus.result <= res_next;
                    bus.address <= ADDR_W'(int'(r) * (W - 2) + int'(c));
                    bus.store <= 1'b1;
                end
                STORE: begin
                    bus.store <= 1'b0;
                    if (last) begin
                        state <= DONE;
                        bus.done <= 1'b1;
                    end else begin
                        state <= READ;
                        r <= nr;
                        c <= nc;
                        p <= '0;
                        bus.addr1 <= tap_addr(int'(nr), int'(nc), 0, W);
                        bus.addr2 <= tap_addr(int'(nr), int'(nc), 1, W);
                        bus.load <= 1'b1;
                    end
                end
                DONE: if (!bus.conv) begin
                    state <= IDLE;
                    bus.done <= 1'b0;
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_conv3x3_engine.sv
// tb_conv3x3_engine: drives image/kernel patterns and checks every stored pixel against a direct 3x3 sum
module tb_conv3x3_engine;
    localparam int H = 28;
    localparam int W = 28;
    localparam int N = (H - 2) * (W - 2);
    logic clk = 1'b0;
    logic rst;
    int total = 0;
    int bad = 0;
    logic signed [7:0] mem [H*W];
    logic signed [7:0] kern [9];
    int exp_res [N];
    conv_if bus();
    conv3x3_engine #(.H(H), .W(W)) dut (.clk(clk), .rst(rst), .bus(bus));
    always #5 clk = ~clk;
    always @(posedge clk) if (bus.load) begin
        bus.data1 <= mem[bus.addr1];
        bus.data2 <= mem[bus.addr2];
    end
    task automatic chk(input string tag, input int got, input int want);
        total++;
        if (got !== want) begin
            bad++;
            $display("FAIL %s got=%0d want=%0d", tag, got, want);
        end
    endtask
    task automatic build_ref();
        for (int k = 0; k < 9; k++) bus.kernel[k] = kern[k];
        for (int r = 0; r < H - 2; r++)
            for (int c = 0; c < W - 2; c++) begin
                int s = 0;
                for (int k = 0; k < 9; k++) s += int'(mem[(r + k / 3) * W + c + k % 3]) * int'(kern[k]);
                s = s > 127 ? 127 : s < -128 ? -128 : s;
`ifdef RELU_EN
                if (s < 0) s = 0;
`endif
                exp_res[r * (W - 2) + c] = s;
            end
    endtask
    task automatic run_pass(input string tag, input int exp_cyc, input int abort_at);
        int n = 0;
        int cyc = 0;
        while (!bus.done && cyc < 6000 && !(abort_at >= 0 && n == abort_at)) begin
            @(posedge clk);
            cyc++;
            @(negedge clk);
            if (bus.store) begin
                chk({tag, "_res"}, int'(bus.result), n < N ? exp_res[n] : 0);
                chk({tag, "_addr"}, int'(bus.address), n);
                chk({tag, "_load_in_store"}, int'(bus.load), 0);
                n++;
            end
        end
        if (abort_at < 0) begin
            chk({tag, "_strobes"}, n, N);
            chk({tag, "_done"}, int'(bus.done), 1);
            chk({tag, "_cycles"}, cyc, exp_cyc);
        end
    endtask
    task automatic restart(input string tag);
        bus.conv = 1'b0;
        @(posedge clk);
        @(negedge clk);
        chk({tag, "_done_drop"}, int'(bus.done), 0);
        chk({tag, "_idle_load"}, int'(bus.load), 0);
        bus.conv = 1'b1;
        run_pass(tag, N * 7 + 1, -1);
    endtask
    initial begin
        rst = 1'b1;
        bus.conv = 1'b1;
        for (int i = 0; i < H; i++) for (int j = 0; j < W; j++) mem[i * W + j] = 8'(i);
        for (int k = 0; k < 9; k++) kern[k] = 8'(k < 3 ? -1 : k > 5 ? 1 : 0);
        build_ref();
        repeat (2) @(posedge clk);
        @(negedge clk);
        chk("rst_addr1", int'(bus.addr1), 0);
        chk("rst_addr2", int'(bus.addr2), 0);
        chk("rst_result", int'(bus.result), 0);
        chk("rst_address", int'(bus.address), 0);
        chk("rst_load", int'(bus.load), 0);
        chk("rst_store", int'(bus.store), 0);
        chk("rst_done", int'(bus.done), 0);
        rst = 1'b0;
        @(posedge clk);
        @(negedge clk);
        chk("first_load", int'(bus.load), 1);
        chk("first_addr1", int'(bus.addr1), 0);
        chk("first_addr2", int'(bus.addr2), 1);
        run_pass("ramp", N * 7, -1);
        restart("ramp_again");
        bus.conv = 1'b0;
        @(posedge clk);
        @(negedge clk);
        bus.conv = 1'b1;
        run_pass("abort", 0, 100);
        rst = 1'b1;
        @(posedge clk);
        @(negedge clk);
        chk("mid_rst_store", int'(bus.store), 0);
        chk("mid_rst_result", int'(bus.result), 0);
        chk("mid_rst_address", int'(bus.address), 0);
        chk("mid_rst_load", int'(bus.load), 0);
        rst = 1'b0;
        run_pass("after_rst", N * 7 + 1, -1);
        for (int i = 0; i < H; i++) for (int j = 0; j < W; j++) mem[i * W + j] = 8'((i * W + j) & 63);
        for (int k = 0; k < 9; k++) kern[k] = 8'(k == 4 ? 1 : 0);
        build_ref();
        restart("ident");
        for (int i = 0; i < H * W; i++) mem[i] = 8'sd127;
        for (int k = 0; k < 9; k++) kern[k] = 8'sd127;
        build_ref();
        restart("sat_hi");
        for (int k = 0; k < 9; k++) kern[k] = -8'sd128;
        build_ref();
        restart("sat_lo");
        for (int i = 0; i < H * W; i++) mem[i] = 8'($urandom);
        for (int k = 0; k < 9; k++) kern[k] = 8'($urandom);
        build_ref();
        restart("rand");
        for (int i = 0; i < H * W; i++) mem[i] = 8'($urandom_range(0, 15) - 8);
        for (int k = 0; k < 9; k++) kern[k] = 8'($urandom_range(0, 7) - 4);
        build_ref();
        restart("rand_small");
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
